// File: rtl/rip_branch_resolver.sv
// rip_branch_resolver: tracks in-flight predicted branches in a small FIFO,
// compares each against its execute-stage outcome, emits the predictor training
// strobe and, on a misprediction, a flush pulse plus the corrected fetch PC.
// Optional feature macro: BRANCH_STATS_EN adds consume/mispredict counters.

package rip_branch_resolver_pkg;

  localparam int unsigned ADDR_W = 32;

  // One in-flight predicted branch as recorded at fetch.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
  } br_entry_t;

endpackage

module rip_branch_resolver
  import rip_branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_pc,
  input  logic        push_taken,
  input  logic [31:0] push_target,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        update,
  output logic        actual,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        underflow
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  br_entry_t          fifo_q [DEPTH];
  br_entry_t          fifo_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Registered outputs
  logic               update_q, update_d;
  logic               actual_q, actual_d;
  logic               flush_q, flush_d;
  logic [ADDR_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic               underflow_q, underflow_d;

`ifdef BRANCH_STATS_EN
  logic [31:0]        br_count_q, br_count_d;
  logic [31:0]        mispred_count_q, mispred_count_d;
`endif

  // Per-cycle decode
  br_entry_t          head;
  br_entry_t          push_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               consume;
  logic               mispredict_now;
  logic               push_fire;
  logic               res_on_empty;

  // Status flags, head entry and the accept/consume/mispredict decisions
  always_comb begin
    head        = fifo_q[rd_ptr_q];
    push_entry  = '{pc: push_pc, taken: push_taken, target: push_target};
    fifo_full   = (count_q == CNT_W'(DEPTH));
    fifo_empty  = (count_q == '0);
    push_ready  = !fifo_full && !stall;
    consume     = res_valid && !stall && !fifo_empty;
    res_on_empty = res_valid && !stall && fifo_empty;
    mispredict_now = 1'b0;
    if (consume) begin
      mispredict_now = (head.taken != res_taken) ||
                       (head.taken && res_taken && (head.target != res_target));
    end
    // A mispredict squashes everything younger, including this cycle's push.
    push_fire = push_valid && push_ready && !mispredict_now;
  end

  // Next-state for FIFO pointers, count and the registered outputs
  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    update_d      = 1'b0;
    flush_d       = 1'b0;
    actual_d      = actual_q;
    redirect_pc_d = redirect_pc_q;
    underflow_d   = underflow_q;

    if (push_fire) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    if (consume) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      update_d = 1'b1;
      actual_d = res_taken;
    end

    if (mispredict_now) begin
      // push_fire is already suppressed, so wr_ptr_q is the new empty point.
      count_d       = '0;
      rd_ptr_d      = wr_ptr_q;
      flush_d       = 1'b1;
      redirect_pc_d = res_taken ? res_target : (head.pc + ADDR_W'(4));
    end else begin
      unique case ({push_fire, consume})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (res_on_empty) begin
      underflow_d = 1'b1;
    end
  end

`ifdef BRANCH_STATS_EN
  // Statistics counters advance with the consume; stall blocks consume so they freeze
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (consume) begin
      br_count_d = br_count_q + 32'(1);
    end
    if (mispredict_now) begin
      mispred_count_d = mispred_count_q + 32'(1);
    end
  end

  // Statistics counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
`endif

  // FIFO entry storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  // Pointer, count and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      update_q      <= 1'b0;
      actual_q      <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      update_q      <= update_d;
      actual_q      <= actual_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      underflow_q   <= underflow_d;
    end
  end

  assign update      = update_q;
  assign actual      = actual_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_rip_branch_resolver.sv
// Bench for rip_branch_resolver: directed scenarios plus randomized traffic,
// checked against a queue-based reference model through a scoreboard.
// Honours BRANCH_STATS_EN to connect and check the statistics counters.
module tb_rip_branch_resolver;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } mdl_entry_t;

  typedef struct {
    logic        actual;
    logic        flush;
    logic [31:0] redirect;
  } exp_resp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_pc = '0;
  logic        push_taken = 1'b0;
  logic [31:0] push_target = '0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        update;
  logic        actual;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        underflow;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;
`endif

  rip_branch_resolver #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rstn(rstn),
    .stall(stall),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_pc(push_pc),
    .push_taken(push_taken),
    .push_target(push_target),
    .res_valid(res_valid),
    .res_taken(res_taken),
    .res_target(res_target),
    .update(update),
    .actual(actual),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .underflow(underflow)
`ifdef BRANCH_STATS_EN
    ,
    .br_count(br_count),
    .mispred_count(mispred_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  mdl_entry_t  mq[$];
  exp_resp_t   exp_q[$];
  logic        m_underflow = 1'b0;
  logic [31:0] m_br = '0;
  logic [31:0] m_mis = '0;
  logic        last_actual = 1'b0;
  logic [31:0] last_redirect = '0;
  bit          run = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One cycle: check registered state, drive inputs, advance the model
  task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                      input logic [31:0] ptg, input logic rv, input logic rt,
                      input logic [31:0] rtg, input logic st);
    logic       exp_ready, cons, mis, acc;
    mdl_entry_t h, ne;
    exp_resp_t  e;
    @(negedge clk);
    chk("underflow", 32'(underflow), 32'(m_underflow));
`ifdef BRANCH_STATS_EN
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mis);
`endif
    push_valid = pv; push_pc = pc; push_taken = pt; push_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg; stall = st;
    #1;
    exp_ready = !st && (mq.size() < DEPTH);
    chk("push_ready", 32'(push_ready), 32'(exp_ready));
    cons = rv && !st && (mq.size() != 0);
    mis = 1'b0;
    if (cons) begin
      h = mq[0];
      mis = (h.taken != rt) || (h.taken && rt && (h.target != rtg));
      e.actual = rt;
      e.flush = mis;
      e.redirect = rt ? rtg : h.pc + 32'd4;
      exp_q.push_back(e);
      m_br = m_br + 32'd1;
      if (mis) m_mis = m_mis + 32'd1;
    end
    if (rv && !st && (mq.size() == 0)) m_underflow = 1'b1;
    acc = pv && exp_ready && !mis;
    if (mis) mq.delete();
    else if (cons) void'(mq.pop_front());
    if (acc) begin
      ne.pc = pc; ne.taken = pt; ne.target = ptg;
      mq.push_back(ne);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
    step(1'b1, pc, pt, ptg, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtg, input logic st);
    step(1'b0, '0, 1'b0, '0, 1'b1, rt, rtg, st);
  endtask

  // Asynchronous reset; outputs must clear without waiting for a clock edge
  task automatic do_reset();
    @(negedge clk);
    push_valid = 1'b0; res_valid = 1'b0; stall = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_actual", 32'(actual), 32'd0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
`ifdef BRANCH_STATS_EN
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mispred_count", mispred_count, 32'd0);
`endif
    mq.delete(); exp_q.delete();
    m_underflow = 1'b0; m_br = '0; m_mis = '0;
    last_actual = 1'b0; last_redirect = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run = 1'b1;
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT strobes update
  initial begin
    exp_resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (run && rstn) begin
        if (update === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("spurious_update", 32'(update), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("flush", 32'(flush), 32'(e.flush));
            last_actual = e.actual;
            if (e.flush) last_redirect = e.redirect;
          end
        end else begin
          chk("flush_without_update", 32'(flush), 32'd0);
        end
        chk("actual", 32'(actual), 32'(last_actual));
        chk("redirect_pc", redirect_pc, last_redirect);
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pv, pt, rv, rt, st;
    logic [31:0] pc, ptg, rtg;
    int          r;

    do_reset();

    // Correct prediction
    push(32'h100, 1'b1, 32'h200);
    resolve(1'b1, 32'h200, 1'b0);
    idle();

    // Direction mispredict with a younger branch squashed
    push(32'h100, 1'b1, 32'h200);
    push(32'h104, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, 1'b0);
    idle();
    idle();

    // Target mispredict
    push(32'h180, 1'b1, 32'h200);
    resolve(1'b1, 32'h300, 1'b0);
    idle();

    // Not-taken mispredict at the top of the address space wraps the fall-through
    push(32'hFFFF_FFFC, 1'b1, 32'h40);
    resolve(1'b0, 32'h0, 1'b0);
    idle();

    // Fill, stall with resolve pending, then drain in order
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i));
    push(32'h9999, 1'b0, 32'h0);
    resolve(1'b1, 32'h2000, 1'b1);
    resolve(1'b1, 32'h2000, 1'b1);
    // Consume at full does not open the push port in the same cycle
    step(1'b1, 32'h7777, 1'b0, '0, 1'b1, 1'b1, 32'h2000, 1'b0);
    for (int i = 1; i < DEPTH; i++) resolve(1'b1, 32'h2000 + 32'(i), 1'b0);
    idle();

    // Resolve with an empty FIFO sets the sticky underflow flag
    resolve(1'b1, 32'h0, 1'b0);
    idle();
    idle();

    // Reset in the middle of traffic discards in-flight entries
    push(32'h500, 1'b1, 32'h600);
    push(32'h504, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, 1'b0);
    push(32'h508, 1'b1, 32'h700);
    do_reset();
    resolve(1'b1, 32'h700, 1'b0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      pv  = ($urandom_range(0, 9) < 6);
      pc  = $urandom & 32'hFFFF_FFFC;
      pt  = $urandom_range(0, 1);
      r   = $urandom_range(0, 2);
      ptg = (r == 0) ? 32'h200 : (r == 1) ? 32'h300 : $urandom;
      rv  = ($urandom_range(0, 9) < 5);
      st  = ($urandom_range(0, 99) < 15);
      if (mq.size() != 0 && $urandom_range(0, 9) < 7) begin
        rt  = mq[0].taken;
        rtg = mq[0].taken ? mq[0].target : $urandom;
      end else begin
        rt  = $urandom_range(0, 1);
        r   = $urandom_range(0, 1);
        rtg = (r == 0) ? 32'h200 : 32'h300;
      end
      step(pv, pc, pt, ptg, rv, rt, rtg, st);
    end

    idle();
    idle();
    idle();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
